// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store per three cycles, sizes and steers
// bytes for RV32I funct3 encodings, and answers with a single-cycle response pulse.
module data_mem_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_MEM_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o
);
    localparam int IDX_W = $clog2(DATA_MEM_DEPTH);
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_reg, state_next;
    logic                  we_reg;
    logic [2:0]            funct3_reg;
    logic [DATA_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  accept;

    assign req_ready_o = (state_reg == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'd0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= req_we_i;
                funct3_reg <= req_funct3_i;
                addr_reg   <= req_addr_i;
                wdata_reg  <= req_wdata_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Fault detection works on the captured request so late input changes cannot matter.
    logic             is_half, is_word, range_err, misalign, funct3_bad, req_err;
    logic [1:0]       lane;
    logic [IDX_W-1:0] word_idx;

    assign lane       = addr_reg[1:0];
    assign word_idx   = addr_reg[IDX_W+1:2];
    assign is_half    = (funct3_reg[1:0] == 2'b01);
    assign is_word    = (funct3_reg[1:0] == 2'b10);
    assign range_err  = |addr_reg[DATA_WIDTH-1:IDX_W+2];
    assign misalign   = (is_half && addr_reg[0]) || (is_word && (lane != 2'b00));
    assign funct3_bad = we_reg ? (funct3_reg > 3'd2)
                               : ((funct3_reg == 3'd3) || (funct3_reg == 3'd6) || (funct3_reg == 3'd7));
    assign req_err    = range_err || misalign || funct3_bad;

    logic [LANES-1:0]      byte_en;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic                  wr_en, rd_en;

    always_comb begin
        byte_en    = '1;
        wdata_lane = wdata_reg;
        case (funct3_reg[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << lane;
                wdata_lane = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_reg[15:0]}};
            end
            default: begin
                byte_en    = '1;
                wdata_lane = wdata_reg;
            end
        endcase
    end

    // An asynchronous reset during ACCESS drops the state, which cancels the pending write.
    assign wr_en = (state_reg == ACCESS) && we_reg && !req_err;
    assign rd_en = (state_reg == ACCESS) && !we_reg;

    logic [LANES-1:0][7:0] rd_word;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DATA_MEM_DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (wr_en && byte_en[gi]) begin
                    mem[word_idx] <= wdata_lane[8*gi +: 8];
                end
                if (rd_en) begin
                    rd_byte_reg <= mem[word_idx];
                end
            end

            assign rd_word[gi] = rd_byte_reg;
        end
    endgenerate

    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign sel_byte = rd_word[lane];
    assign sel_half = lane[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};

    always_comb begin
        load_data = rd_word;
        case (funct3_reg)
            3'd0:    load_data = {{24{sel_byte[7]}}, sel_byte};
            3'd4:    load_data = {24'd0, sel_byte};
            3'd1:    load_data = {{16{sel_half[15]}}, sel_half};
            3'd5:    load_data = {16'd0, sel_half};
            default: load_data = rd_word;
        endcase
    end

    assign resp_valid_o = (state_reg == RESP);
    assign resp_err_o   = (state_reg == RESP) && req_err;
    assign resp_rdata_o = ((state_reg == RESP) && !req_err && !we_reg) ? load_data : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected responses are queued at issue time
// and matched against each response pulse by a negedge monitor.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam logic [2:0] F_B  = 3'd0;
    localparam logic [2:0] F_H  = 3'd1;
    localparam logic [2:0] F_W  = 3'd2;
    localparam logic [2:0] F_BU = 3'd4;
    localparam logic [2:0] F_HU = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_resp = 0;
    int   cycle = 0;

    data_mem_responder #(.DATA_WIDTH(32), .DATA_MEM_DEPTH(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        if (rst_n && resp_valid_o) begin
            exp_t e;
            n_resp++;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {31'd0, resp_valid_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", {31'd0, resp_err_o}, {31'd0, e.err});
                check("resp_rdata", resp_rdata_o, e.data);
            end
        end
    end

    task automatic push_exp(input logic err, input logic [31:0] data);
        exp_t e;
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_data);
        @(negedge clk);
        check("ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(posedge clk);
        #1;
        push_exp(exp_err, exp_data);
        req_valid_i  = 1'b0;
        req_we_i     = 1'($urandom);
        req_funct3_i = 3'($urandom);
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
        $display("txn we=%0d f3=%0d addr=%h wdata=%h exp_err=%0d exp_rdata=%h",
                 we, f3, addr, wdata, exp_err, exp_data);
        @(negedge clk);
        check("ready_access", {31'd0, req_ready_o}, 32'd0);
        check("valid_access", {31'd0, resp_valid_o}, 32'd0);
        @(negedge clk);
        check("ready_resp", {31'd0, req_ready_o}, 32'd0);
        check("valid_resp", {31'd0, resp_valid_o}, 32'd1);
        @(negedge clk);
        check("ready_back", {31'd0, req_ready_o}, 32'd1);
        check("valid_back", {31'd0, resp_valid_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        b_we  [4];
        logic [2:0]  b_f3  [4];
        logic [31:0] b_ad  [4];
        logic [31:0] b_wd  [4];
        logic [31:0] b_exp [4];
        int          acc   [4];
        int          waited;
        int          resp_before;

        #2;
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_valid", {31'd0, resp_valid_o}, 32'd0);
        check("rst_rdata", resp_rdata_o, 32'd0);
        check("rst_err", {31'd0, resp_err_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, F_W,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(1'b0, F_W,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
        issue(1'b1, F_B,  32'h13, 32'hFFFFFF80, 1'b0, 32'h0);
        issue(1'b0, F_W,  32'h10, 32'h0,        1'b0, 32'h80ADBEEF);
        issue(1'b0, F_B,  32'h13, 32'h0,        1'b0, 32'hFFFFFF80);
        issue(1'b0, F_BU, 32'h13, 32'h0,        1'b0, 32'h00000080);
        issue(1'b0, F_H,  32'h12, 32'h0,        1'b0, 32'hFFFF80AD);
        issue(1'b0, F_HU, 32'h12, 32'h0,        1'b0, 32'h000080AD);
        issue(1'b0, F_B,  32'h10, 32'h0,        1'b0, 32'hFFFFFFEF);
        issue(1'b0, F_BU, 32'h11, 32'h0,        1'b0, 32'h000000BE);
        issue(1'b1, F_H,  32'h16, 32'hA5A51234, 1'b0, 32'h0);
        issue(1'b0, F_HU, 32'h16, 32'h0,        1'b0, 32'h00001234);
        issue(1'b0, F_H,  32'h16, 32'h0,        1'b0, 32'h00001234);

        // Faulting requests must not touch memory
        issue(1'b1, F_H,  32'h11,   32'h0000FFFF, 1'b1, 32'h0);
        issue(1'b0, F_W,  32'h12,   32'h0,        1'b1, 32'h0);
        issue(1'b0, F_W,  32'h10,   32'h0,        1'b0, 32'h80ADBEEF);
        issue(1'b0, F_W,  32'h1000, 32'h0,        1'b1, 32'h0);
        issue(1'b1, 3'd3, 32'h10,   32'h11111111, 1'b1, 32'h0);
        issue(1'b0, 3'd6, 32'h10,   32'h0,        1'b1, 32'h0);
        issue(1'b0, 3'd3, 32'h10,   32'h0,        1'b1, 32'h0);
        issue(1'b1, F_W,  32'h1010, 32'h22222222, 1'b1, 32'h0);
        issue(1'b0, F_W,  32'h10,   32'h0,        1'b0, 32'h80ADBEEF);

        // Back-to-back with valid held; next request appears while the previous is in ACCESS
        b_we[0] = 1'b1; b_f3[0] = F_W; b_ad[0] = 32'h30; b_wd[0] = 32'h11223344; b_exp[0] = 32'h0;
        b_we[1] = 1'b0; b_f3[1] = F_W; b_ad[1] = 32'h30; b_wd[1] = 32'h0;        b_exp[1] = 32'h11223344;
        b_we[2] = 1'b1; b_f3[2] = F_B; b_ad[2] = 32'h31; b_wd[2] = 32'h000000FF; b_exp[2] = 32'h0;
        b_we[3] = 1'b0; b_f3[3] = F_W; b_ad[3] = 32'h30; b_wd[3] = 32'h0;        b_exp[3] = 32'h1122FF44;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = b_we[0];
        req_funct3_i = b_f3[0];
        req_addr_i   = b_ad[0];
        req_wdata_i  = b_wd[0];
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            while (!req_ready_o && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            check("b2b_ready", {31'd0, req_ready_o}, 32'd1);
            acc[i] = cycle;
            @(posedge clk);
            #1;
            push_exp(1'b0, b_exp[i]);
            $display("txn b2b%0d we=%0d f3=%0d addr=%h wdata=%h exp_rdata=%h",
                     i, b_we[i], b_f3[i], b_ad[i], b_wd[i], b_exp[i]);
            if (i < 3) begin
                req_we_i     = b_we[i+1];
                req_funct3_i = b_f3[i+1];
                req_addr_i   = b_ad[i+1];
                req_wdata_i  = b_wd[i+1];
            end else begin
                req_valid_i = 1'b0;
            end
            if (i > 0) check("b2b_spacing", acc[i] - acc[i-1], 32'd3);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("b2b_drained", exp_q.size(), 32'd0);

        // Reset during ACCESS discards the store and suppresses its response
        issue(1'b1, F_W, 32'h20, 32'h12345678, 1'b0, 32'h0);
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = F_W;
        req_addr_i   = 32'h20;
        req_wdata_i  = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        $display("txn aborted SW addr=00000020 wdata=ffffffff (reset during ACCESS)");
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, req_ready_o}, 32'd1);
        check("abort_valid", {31'd0, resp_valid_o}, 32'd0);
        check("abort_rdata", resp_rdata_o, 32'd0);
        check("abort_err", {31'd0, resp_err_o}, 32'd0);
        resp_before = n_resp;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_resp", n_resp, resp_before);
        issue(1'b0, F_W, 32'h20, 32'h0, 1'b0, 32'h12345678);

        repeat (2) @(negedge clk);
        check("final_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
